// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: ID read/issue and WB write bundle between the pipeline and the register file
interface reg_file_wb_if #(parameter int XLEN = 32);
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic            id_issue;
    logic [4:0]      id_rd;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_write_data;
    logic            rf_stall;
    logic            sb_overflow;
    logic            sb_underflow;
    modport master (
        output id_rs1, id_rs2, id_issue, id_rd, wb_reg_write, wb_rd, wb_write_data,
        input  id_rs1_data, id_rs2_data, rf_stall, sb_overflow, sb_underflow
    );
    modport slave (
        input  id_rs1, id_rs2, id_issue, id_rd, wb_reg_write, wb_rd, wb_write_data,
        output id_rs1_data, id_rs2_data, rf_stall, sb_overflow, sb_underflow
    );
endinterface

// File: rtl/reg_file_wb.sv
// reg_file_wb: 32xXLEN register file with WB write port and RAW scoreboard; REGFILE_BYPASS_EN enables write-first read bypass
module reg_file_wb #(
    parameter int XLEN     = 32,
    parameter int SB_CNT_W = 2
) (
    input logic              clk,
    input logic              rst,
    reg_file_wb_if.slave     bus_io
);
    localparam logic [SB_CNT_W-1:0] cnt_max = '1;
    logic [XLEN-1:0]     regs_q [32];
    logic [SB_CNT_W-1:0] cnt_q  [32];
    logic [SB_CNT_W-1:0] cnt_d  [32];
    logic                ovf_q, ovf_d, unf_q, unf_d;
    logic [31:0]         inc_v, dec_v;
    logic                byp1, byp2, busy1, busy2;
    assign inc_v = (bus_io.id_issue && bus_io.id_rd != 5'd0) ? 32'd1 << bus_io.id_rd : 32'd0;
    assign dec_v = (bus_io.wb_reg_write && bus_io.wb_rd != 5'd0) ? 32'd1 << bus_io.wb_rd : 32'd0;
`ifdef REGFILE_BYPASS_EN
    assign byp1 = dec_v[bus_io.id_rs1];
    assign byp2 = dec_v[bus_io.id_rs2];
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif
    // With bypass, the retiring write of the last pending count is already visible, so no stall
    assign busy1 = cnt_q[bus_io.id_rs1] != '0 && !(byp1 && cnt_q[bus_io.id_rs1] == SB_CNT_W'(1));
    assign busy2 = cnt_q[bus_io.id_rs2] != '0 && !(byp2 && cnt_q[bus_io.id_rs2] == SB_CNT_W'(1));
    assign bus_io.id_rs1_data  = rst ? '0 : byp1 ? bus_io.wb_write_data : regs_q[bus_io.id_rs1];
    assign bus_io.id_rs2_data  = rst ? '0 : byp2 ? bus_io.wb_write_data : regs_q[bus_io.id_rs2];
    assign bus_io.rf_stall     = !rst && (busy1 || busy2);
    assign bus_io.sb_overflow  = ovf_q;
    assign bus_io.sb_underflow = unf_q;
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_v[r] && !dec_v[r]) begin
                if (cnt_q[r] == cnt_max) ovf_d = 1'b1;
                else cnt_d[r] = cnt_q[r] + SB_CNT_W'(1);
            end else if (dec_v[r] && !inc_v[r]) begin
                if (cnt_q[r] == '0) unf_d = 1'b1;
                else cnt_d[r] = cnt_q[r] - SB_CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (dec_v[bus_io.wb_rd]) regs_q[bus_io.wb_rd] <= bus_io.wb_write_data;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed and random checks of reg_file_wb against an array/counter model
module tb_reg_file_wb;
`ifdef REGFILE_BYPASS_EN
    localparam bit byp = 1'b1;
`else
    localparam bit byp = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] mreg [32];
    int mcnt [32];
    bit movf, munf;
    reg_file_wb_if #(.XLEN(32)) bus ();
    reg_file_wb #(.XLEN(32), .SB_CNT_W(2)) dut (.clk(clk), .rst(rst), .bus_io(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] exp_rd(input logic [4:0] s);
        if (s == 5'd0) return 32'd0;
        if (byp && bus.wb_reg_write && bus.wb_rd == s) return bus.wb_write_data;
        return mreg[s];
    endfunction
    function automatic bit busy(input logic [4:0] s);
        if (s == 5'd0 || mcnt[s] == 0) return 1'b0;
        return !(byp && bus.wb_reg_write && bus.wb_rd == s && mcnt[s] == 1);
    endfunction
    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            mreg[r] = 32'd0;
            mcnt[r] = 0;
        end
        movf = 1'b0;
        munf = 1'b0;
    endtask
    task automatic model_step();
        for (int r = 1; r < 32; r++) begin
            bit i, d;
            i = bus.id_issue && bus.id_rd == 5'(r);
            d = bus.wb_reg_write && bus.wb_rd == 5'(r);
            if (i && !d) begin
                if (mcnt[r] == 3) movf = 1'b1;
                else mcnt[r]++;
            end else if (d && !i) begin
                if (mcnt[r] == 0) munf = 1'b1;
                else mcnt[r]--;
            end
        end
        if (bus.wb_reg_write && bus.wb_rd != 5'd0) mreg[bus.wb_rd] = bus.wb_write_data;
    endtask
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic iss,
                         input logic [4:0] rd, input logic we, input logic [4:0] wrd,
                         input logic [31:0] wdata);
        bus.id_rs1 = rs1;
        bus.id_rs2 = rs2;
        bus.id_issue = iss;
        bus.id_rd = rd;
        bus.wb_reg_write = we;
        bus.wb_rd = wrd;
        bus.wb_write_data = wdata;
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".rs1"}, bus.id_rs1_data, exp_rd(bus.id_rs1));
        chk({tag, ".rs2"}, bus.id_rs2_data, exp_rd(bus.id_rs2));
        chk({tag, ".stall"}, 32'(bus.rf_stall), 32'(busy(bus.id_rs1) | busy(bus.id_rs2)));
        chk({tag, ".ovf"}, 32'(bus.sb_overflow), 32'(movf));
        chk({tag, ".unf"}, 32'(bus.sb_underflow), 32'(munf));
    endtask
    task automatic cyc(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic iss, input logic [4:0] rd, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wdata);
        drive(rs1, rs2, iss, rd, we, wrd, wdata);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic areset(input string tag);
        logic [4:0] s;
        s = 5'($urandom_range(1, 31));
        #2 rst = 1'b1;
        drive(s, 5'd5, 1'b1, s, 1'b1, s, 32'hCAFE_F00D);
        model_reset();
        #1;
        chk({tag, ".rs1"}, bus.id_rs1_data, 32'd0);
        chk({tag, ".rs2"}, bus.id_rs2_data, 32'd0);
        chk({tag, ".stall"}, 32'(bus.rf_stall), 32'd0);
        chk({tag, ".ovf"}, 32'(bus.sb_overflow), 32'd0);
        chk({tag, ".unf"}, 32'(bus.sb_underflow), 32'd0);
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask
    initial begin
        drive(5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        model_reset();
        #2;
        chk("por.rs1", bus.id_rs1_data, 32'd0);
        chk("por.stall", 32'(bus.rf_stall), 32'd0);
        chk("por.flags", {30'd0, bus.sb_overflow, bus.sb_underflow}, 32'd0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("wr5",   5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        cyc("rd5",   5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("rd5.lit", bus.id_rs1_data, 32'hDEAD_BEEF);
        cyc("wr0",   5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h1234);
        cyc("rd0",   5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("rd0.lit", bus.id_rs2_data, 32'd0);
        cyc("byp7",  5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hA5A5_A5A5);
        cyc("rd7",   5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc("iss3",  5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
        cyc("raw3",  5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc("wb3",   5'd0, 5'd3, 1'b0, 5'd0, 1'b1, 5'd3, 32'h0000_0033);
        cyc("post3", 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc("iss9a", 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
        cyc("iss9b", 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
        cyc("wb9a",  5'd9, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_0909);
        cyc("st9",   5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc("iw9",   5'd9, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h0000_0999);
        cyc("st9b",  5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc("wb9b",  5'd9, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h0000_9999);
        cyc("free9", 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 4; k++) cyc("iss4", 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
        cyc("ovf",   5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("ovf.lit", 32'(bus.sb_overflow), 32'd1);
        for (int k = 0; k < 3; k++) cyc("drain4", 5'd4, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'(k));
        cyc("free4", 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        cyc("unf6",  5'd6, 5'd6, 1'b0, 5'd0, 1'b1, 5'd6, 32'h0000_0666);
        cyc("unfchk", 5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        chk("unf.lit", 32'(bus.sb_underflow), 32'd1);
        areset("arst1");
        cyc("post_rst", 5'd5, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 400; k++)
            cyc("rand", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        areset("arst2");
        for (int k = 0; k < 200; k++)
            cyc("rand2", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
